// File: rtl/lsm_sequencer.sv
// LDM/STM register-list sequencer: walks the 16-bit register list one bit per cycle
// and issues a handshaked transfer for every set bit.
module lsm_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsm_start,
    input  logic        ir_23,
    input  logic [15:0] reg_list,
    input  logic        lsm_detect,
    input  logic        lsm_end,
    input  logic        xfer_ack,
    output logic        lsm_en,
    output logic        lsmahr_0,
    output logic        lsmahr_15,
    output logic [3:0]  lsm_counter,
    output logic [3:0]  lsm_reg_addr,
    output logic        xfer_req,
    output logic [4:0]  lsm_reg_count,
    output logic        lsm_busy,
    output logic        lsm_done
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        XFER,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] lsmahr;
    logic        scan_down;
    logic        load;
    logic        step;
    logic        req_set;
    logic        req_clr;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        req_set    = 1'b0;
        req_clr    = 1'b0;
        lsm_en     = 1'b0;
        lsm_busy   = 1'b1;
        lsm_done   = 1'b0;
        case (state)
            IDLE: begin
                lsm_busy = 1'b0;
                if (lsm_start) begin
                    load       = 1'b1;
                    next_state = CHECK;
                end
            end
            CHECK: begin
                lsm_en = 1'b1;
                if (lsm_detect) begin
                    req_set    = 1'b1;
                    next_state = XFER;
                end else if (lsm_end) begin
                    next_state = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            XFER: begin
                lsm_en = 1'b1;
                if (xfer_ack) begin
                    req_clr = 1'b1;
                    if (lsm_end) begin
                        next_state = DONE;
                    end else begin
                        step       = 1'b1;
                        next_state = CHECK;
                    end
                end
            end
            DONE: begin
                lsm_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Stepping is suppressed at the terminal index, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            lsmahr        <= '0;
            lsm_counter   <= '0;
            scan_down     <= 1'b0;
            lsm_reg_count <= '0;
            lsm_reg_addr  <= '0;
            xfer_req      <= 1'b0;
        end else begin
            if (load) begin
                lsmahr        <= reg_list;
                lsm_counter   <= ir_23 ? 4'd15 : 4'd0;
                scan_down     <= ir_23;
                lsm_reg_count <= popcount16(reg_list);
            end else if (step) begin
                if (scan_down) begin
                    lsmahr      <= {lsmahr[14:0], 1'b0};
                    lsm_counter <= lsm_counter - 4'd1;
                end else begin
                    lsmahr      <= {1'b0, lsmahr[15:1]};
                    lsm_counter <= lsm_counter + 4'd1;
                end
            end
            if (req_set) begin
                xfer_req     <= 1'b1;
                lsm_reg_addr <= lsm_counter;
            end else if (req_clr) begin
                xfer_req <= 1'b0;
            end
        end
    end

    assign lsmahr_0  = lsmahr[0];
    assign lsmahr_15 = lsmahr[15];

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer; models the external check stage from the
// edge bits and counter, and drives the transfer handshake with a set delay.
module tb_lsm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsm_start;
    logic        ir_23;
    logic [15:0] reg_list;
    logic        lsm_detect;
    logic        lsm_end;
    logic        xfer_ack;
    logic        lsm_en;
    logic        lsmahr_0;
    logic        lsmahr_15;
    logic [3:0]  lsm_counter;
    logic [3:0]  lsm_reg_addr;
    logic        xfer_req;
    logic [4:0]  lsm_reg_count;
    logic        lsm_busy;
    logic        lsm_done;

    logic        u_model = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [3:0]  addrs[$];
    int          done_cycles;
    bit          timed_out;
    int          unstable;

    always #5 clk = ~clk;

    // Check stage: edge bit selected by scan direction, terminal index by direction.
    assign lsm_detect = u_model ? lsmahr_15 : lsmahr_0;
    assign lsm_end    = u_model ? (lsm_counter == 4'd0) : (lsm_counter == 4'd15);

    lsm_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .lsm_start    (lsm_start),
        .ir_23        (ir_23),
        .reg_list     (reg_list),
        .lsm_detect   (lsm_detect),
        .lsm_end      (lsm_end),
        .xfer_ack     (xfer_ack),
        .lsm_en       (lsm_en),
        .lsmahr_0     (lsmahr_0),
        .lsmahr_15    (lsmahr_15),
        .lsm_counter  (lsm_counter),
        .lsm_reg_addr (lsm_reg_addr),
        .xfer_req     (xfer_req),
        .lsm_reg_count(lsm_reg_count),
        .lsm_busy     (lsm_busy),
        .lsm_done     (lsm_done)
    );

    // Starts a scan and services transfers. done_cycles = number of rising edges from
    // the START edge to the edge that closes the LSM_DONE cycle.
    task automatic run_scan(input logic [15:0] list, input logic u, input int ack_delay);
        int         waited;
        bit         in_xfer;
        logic [3:0] held_addr;
        logic [3:0] held_cnt;
        addrs.delete();
        done_cycles = 0;
        timed_out   = 1'b1;
        unstable    = 0;
        in_xfer     = 1'b0;
        waited      = 0;
        held_addr   = '0;
        held_cnt    = '0;
        @(negedge clk);
        u_model   = u;
        reg_list  = list;
        ir_23     = u;
        lsm_start = 1'b1;
        xfer_ack  = 1'b0;
        @(negedge clk);
        lsm_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (lsm_done === 1'b1) begin
                done_cycles = k + 1;
                timed_out   = 1'b0;
                break;
            end
            if (xfer_req === 1'b1) begin
                if (!in_xfer) begin
                    in_xfer   = 1'b1;
                    waited    = 0;
                    held_addr = lsm_reg_addr;
                    held_cnt  = lsm_counter;
                    addrs.push_back(lsm_reg_addr);
                end else if (lsm_reg_addr !== held_addr || lsm_counter !== held_cnt) begin
                    unstable++;
                end
                xfer_ack = (waited >= ack_delay);
                waited++;
            end else begin
                in_xfer  = 1'b0;
                xfer_ack = 1'b0;
            end
            @(negedge clk);
        end
        xfer_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        lsm_start = 1'b0;
        ir_23     = 1'b0;
        reg_list  = '0;
        xfer_ack  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({lsm_en, lsmahr_0, lsmahr_15, xfer_req, lsm_done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_bits: got %b expected 00000", {lsm_en, lsmahr_0, lsmahr_15, xfer_req, lsm_done});
        end
        total++;
        if ({lsm_counter, lsm_reg_addr, lsm_reg_count} !== 13'd0) begin
            bad++;
            $display("FAIL reset_fields: cnt=%0d addr=%0d regcnt=%0d expected all 0", lsm_counter, lsm_reg_addr, lsm_reg_count);
        end
        total++;
        if (lsm_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b expected 0", lsm_busy);
        end
    endtask

    task automatic test_down_scan();
        run_scan(16'h8001, 1'b1, 0);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL down_timeout: no LSM_DONE within 200 cycles");
        end
        total++;
        if (addrs.size() != 2) begin
            bad++;
            $display("FAIL down_xfer_count: got %0d expected 2", addrs.size());
        end else begin
            total++;
            if (addrs[0] !== 4'd15 || addrs[1] !== 4'd0) begin
                bad++;
                $display("FAIL down_addrs: got %0d,%0d expected 15,0", addrs[0], addrs[1]);
            end
        end
        total++;
        if (done_cycles != 19) begin
            bad++;
            $display("FAIL down_latency: got %0d expected 19", done_cycles);
        end
        total++;
        if (lsm_reg_count !== 5'd2) begin
            bad++;
            $display("FAIL down_regcount: got %0d expected 2", lsm_reg_count);
        end
        @(negedge clk);
        total++;
        if (lsm_done !== 1'b0 || lsm_busy !== 1'b0) begin
            bad++;
            $display("FAIL down_after_done: done=%b busy=%b expected 0 0", lsm_done, lsm_busy);
        end
        total++;
        if (lsm_reg_count !== 5'd2) begin
            bad++;
            $display("FAIL down_regcount_hold: got %0d expected 2", lsm_reg_count);
        end
    endtask

    task automatic test_up_scan();
        run_scan(16'h0006, 1'b0, 3);
        total++;
        if (addrs.size() != 2) begin
            bad++;
            $display("FAIL up_xfer_count: got %0d expected 2", addrs.size());
        end else begin
            total++;
            if (addrs[0] !== 4'd1 || addrs[1] !== 4'd2) begin
                bad++;
                $display("FAIL up_addrs: got %0d,%0d expected 1,2", addrs[0], addrs[1]);
            end
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL up_stable: got %0d changes while waiting expected 0", unstable);
        end
        total++;
        if (done_cycles != 25) begin
            bad++;
            $display("FAIL up_latency: got %0d expected 25", done_cycles);
        end
        total++;
        if (lsm_reg_count !== 5'd2) begin
            bad++;
            $display("FAIL up_regcount: got %0d expected 2", lsm_reg_count);
        end
    endtask

    task automatic test_empty();
        run_scan(16'h0000, 1'b1, 0);
        total++;
        if (addrs.size() != 0) begin
            bad++;
            $display("FAIL empty_xfers: got %0d expected 0", addrs.size());
        end
        total++;
        if (done_cycles != 17) begin
            bad++;
            $display("FAIL empty_latency: got %0d expected 17", done_cycles);
        end
        total++;
        if (lsm_reg_count !== 5'd0) begin
            bad++;
            $display("FAIL empty_regcount: got %0d expected 0", lsm_reg_count);
        end
    endtask

    task automatic test_full();
        run_scan(16'hFFFF, 1'b1, 0);
        total++;
        if (addrs.size() != 16) begin
            bad++;
            $display("FAIL full_xfer_count: got %0d expected 16", addrs.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (addrs[i] !== 4'(15 - i)) begin
                    bad++;
                    $display("FAIL full_addr[%0d]: got %0d expected %0d", i, addrs[i], 15 - i);
                end
            end
        end
        total++;
        if (lsm_reg_count !== 5'd16) begin
            bad++;
            $display("FAIL full_regcount: got %0d expected 16", lsm_reg_count);
        end
        total++;
        if (done_cycles != 33) begin
            bad++;
            $display("FAIL full_latency: got %0d expected 33", done_cycles);
        end
    endtask

    task automatic test_abort_ignore();
        @(negedge clk);
        u_model   = 1'b0;
        reg_list  = 16'h0003;
        ir_23     = 1'b0;
        lsm_start = 1'b1;
        xfer_ack  = 1'b0;
        @(negedge clk);
        total++;
        if (lsm_en !== 1'b1 || lsm_counter !== 4'd0) begin
            bad++;
            $display("FAIL abort_check_entry: en=%b cnt=%0d expected 1 0", lsm_en, lsm_counter);
        end
        // Second start during CHECK with a different list and direction.
        reg_list = 16'hFFFF;
        ir_23    = 1'b1;
        @(negedge clk);
        lsm_start = 1'b0;
        total++;
        if (xfer_req !== 1'b1 || lsm_reg_addr !== 4'd0) begin
            bad++;
            $display("FAIL abort_first_xfer: req=%b addr=%0d expected 1 0", xfer_req, lsm_reg_addr);
        end
        total++;
        if (lsm_reg_count !== 5'd2 || lsm_counter !== 4'd0) begin
            bad++;
            $display("FAIL ignore_start: regcnt=%0d cnt=%0d expected 2 0", lsm_reg_count, lsm_counter);
        end
        xfer_ack = 1'b1;
        @(negedge clk);
        xfer_ack = 1'b0;
        total++;
        if (xfer_req !== 1'b0 || lsm_counter !== 4'd1) begin
            bad++;
            $display("FAIL abort_step: req=%b cnt=%0d expected 0 1", xfer_req, lsm_counter);
        end
        @(negedge clk);
        total++;
        if (xfer_req !== 1'b1 || lsm_reg_addr !== 4'd1) begin
            bad++;
            $display("FAIL abort_second_xfer: req=%b addr=%0d expected 1 1", xfer_req, lsm_reg_addr);
        end
        reset     = 1'b1;
        lsm_start = 1'b1;
        xfer_ack  = 1'b1;
        @(negedge clk);
        total++;
        if ({lsm_busy, xfer_req, lsm_done, lsm_en, lsmahr_0, lsmahr_15} !== 6'b0) begin
            bad++;
            $display("FAIL abort_reset_bits: got %b expected 000000", {lsm_busy, xfer_req, lsm_done, lsm_en, lsmahr_0, lsmahr_15});
        end
        total++;
        if ({lsm_counter, lsm_reg_addr, lsm_reg_count} !== 13'd0) begin
            bad++;
            $display("FAIL abort_reset_fields: cnt=%0d addr=%0d regcnt=%0d expected all 0", lsm_counter, lsm_reg_addr, lsm_reg_count);
        end
        reset     = 1'b0;
        lsm_start = 1'b0;
        xfer_ack  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (lsm_done !== 1'b0 || lsm_busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done[%0d]: done=%b busy=%b expected 0 0", i, lsm_done, lsm_busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_down_scan();
        test_up_scan();
        test_empty();
        test_full();
        test_abort_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
